softex_streamer_tail_masker: RTL and testbench

- Load-side counterpart of the store-path strobe generator in the softex streamer.
- Consumes the TCDM load stream feeding the datapath and counts beats per transfer.
- On the final beat of a transfer, forces bytes past the vector tail to a neutral pad pattern, clears their strobe bits and flags the beat as last, so the softmax datapath never consumes stale bytes.
- Sits between the HCI load source and the softex datapath input; one registered pipeline stage.

---
 rtl/softex_streamer_tail_masker.sv | 208 ++++++++++++++++++++
 tb/tb_softex_streamer_tail_masker.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/softex_streamer_tail_masker.sv
// Load-side tail masker for the softex streamer: counts beats per transfer and
// pads/unstrobes bytes past the vector tail on the final beat, one register stage.
module softex_streamer_tail_masker #(
  parameter int unsigned      DW        = 256,
  parameter int unsigned      PAD_W     = 16,
  parameter logic [PAD_W-1:0] PAD_VALUE = 16'hFF80
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [31:0]             tot_len_i,
  input  logic [$clog2(DW/8)-1:0] lftovr_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [DW-1:0]           in_data_i,
  input  logic [DW/8-1:0]         in_strb_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [DW-1:0]           out_data_o,
  output logic [DW/8-1:0]         out_strb_o,
  output logic                    out_last_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int unsigned NB = DW / 8;
  localparam int unsigned LW = $clog2(NB);
  localparam int unsigned PB = PAD_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Bytes at or past lftovr take the little-endian pad lane byte and lose their strobe.
  function automatic logic [NB+DW-1:0] mask_beat(
    input logic [DW-1:0] data,
    input logic [NB-1:0] strb,
    input logic [LW-1:0] lftovr
  );
    logic [DW-1:0] d;
    logic [NB-1:0] s;
    d = data;
    s = strb;
    for (int i = 0; i < int'(NB); i++) begin
      if (i >= int'(lftovr)) begin
        d[8*i +: 8] = PAD_VALUE[8*(i % int'(PB)) +: 8];
        s[i]        = 1'b0;
      end else begin
        d[8*i +: 8] = data[8*i +: 8];
        s[i]        = strb[i];
      end
    end
    return {s, d};
  endfunction

  state_e           state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      last_idx_q, last_idx_d;
  logic [LW-1:0]    lftovr_q, lftovr_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic [NB-1:0]    out_strb_q, out_strb_d;
  logic             out_last_q, out_last_d;

  logic             in_hs_s;
  logic             out_hs_s;
  logic             is_final_s;
  logic             mask_en_s;
  logic [NB+DW-1:0] beat_s;

  assign in_ready_o = (state_q == RUN) & ~clear_i & (~out_valid_q | out_ready_i);
  assign in_hs_s    = in_valid_i & in_ready_o;
  assign out_hs_s   = out_valid_q & out_ready_i;
  assign is_final_s = (cnt_q == last_idx_q);
  assign mask_en_s  = is_final_s & (lftovr_q != '0);
  assign beat_s     = mask_en_s ? mask_beat(in_data_i, in_strb_i, lftovr_q)
                                : {in_strb_i, in_data_i};

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_strb_o  = out_strb_q;
  assign out_last_o  = out_last_q;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides every transition
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = (tot_len_i == 32'd0) ? DONE : RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (in_hs_s && is_final_s) begin
            state_d = DRAIN;
          end else begin
            state_d = RUN;
          end
        end
        DRAIN: begin
          if (out_hs_s) begin
            state_d = DONE;
          end else begin
            state_d = DRAIN;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Status outputs decoded from the state register
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      RUN:     busy_o = 1'b1;
      DRAIN:   busy_o = 1'b1;
      DONE:    done_o = 1'b1;
      default: begin
        busy_o = 1'b0;
        done_o = 1'b0;
      end
    endcase
  end

  // Beat counter, latched lengths and output register next values
  always_comb begin
    cnt_d       = cnt_q;
    last_idx_d  = last_idx_q;
    lftovr_d    = lftovr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_strb_d  = out_strb_q;
    out_last_d  = out_last_q;
    if (clear_i) begin
      cnt_d       = 32'd0;
      last_idx_d  = 32'd0;
      lftovr_d    = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_strb_d  = '0;
      out_last_d  = 1'b0;
    end else begin
      if (state_q == IDLE && start_i && tot_len_i != 32'd0) begin
        cnt_d      = 32'd0;
        last_idx_d = tot_len_i - 32'd1;
        lftovr_d   = lftovr_i;
      end else if (in_hs_s) begin
        cnt_d = is_final_s ? 32'd0 : cnt_q + 32'd1;
      end else begin
        cnt_d = cnt_q;
      end
      // A concurrent output handshake is absorbed by the reload
      if (in_hs_s) begin
        out_valid_d = 1'b1;
        out_data_d  = beat_s[DW-1:0];
        out_strb_d  = beat_s[NB+DW-1:DW];
        out_last_d  = is_final_s;
      end else if (out_hs_s) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= 32'd0;
      last_idx_q  <= 32'd0;
      lftovr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      last_idx_q  <= last_idx_d;
      lftovr_q    <= lftovr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_strb_q  <= out_strb_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_softex_streamer_tail_masker.sv
// Directed bench for softex_streamer_tail_masker: per-scenario tasks with inline checks.
module tb_softex_streamer_tail_masker;

  localparam int DW = 256;
  localparam int NB = DW / 8;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            clear_i;
  logic            start_i;
  logic [31:0]     tot_len_i;
  logic [4:0]      lftovr_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [DW-1:0]   in_data_i;
  logic [NB-1:0]   in_strb_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [DW-1:0]   out_data_o;
  logic [NB-1:0]   out_strb_o;
  logic            out_last_o;
  logic            busy_o;
  logic            done_o;

  int pass_cnt  = 0;
  int check_cnt = 0;

  softex_streamer_tail_masker #(
    .DW(256), .PAD_W(16), .PAD_VALUE(16'hFF80)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .tot_len_i(tot_len_i), .lftovr_i(lftovr_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .in_strb_i(in_strb_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_strb_o(out_strb_o), .out_last_o(out_last_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_start(input logic [31:0] len, input logic [4:0] lf);
    start_i   = 1'b1;
    tot_len_i = len;
    lftovr_i  = lf;
    tick();
    start_i   = 1'b0;
  endtask

  task automatic drain_idle();
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0; tot_len_i = 32'd0; lftovr_i = 5'd0;
    in_valid_i = 1'b0; in_data_i = '0; in_strb_i = '0; out_ready_i = 1'b0;
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();
    check_cnt++;
    if ({out_valid_o, out_last_o, busy_o, done_o, in_ready_o} !== 5'b0)
      $display("FAIL reset_ctrl: got %b exp 00000", {out_valid_o, out_last_o, busy_o, done_o, in_ready_o});
    else pass_cnt++;
    check_cnt++;
    if (out_data_o !== '0) $display("FAIL reset_data: got %h exp 0", out_data_o); else pass_cnt++;
    check_cnt++;
    if (out_strb_o !== '0) $display("FAIL reset_strb: got %h exp 0", out_strb_o); else pass_cnt++;
  endtask

  task automatic test_full_pass();
    logic [DW-1:0] d;
    logic [NB-1:0] s;
    out_ready_i = 1'b1;
    do_start(32'd4, 5'd0);
    for (int b = 0; b < 4; b++) begin
      d = {8{32'h1000_0000 + 32'(b)}};
      s = (b == 1) ? 32'h0F0F_0F0F : 32'hFFFF_FFFF;
      in_valid_i = 1'b1; in_data_i = d; in_strb_i = s;
      #1;
      check_cnt++;
      if (in_ready_o !== 1'b1) $display("FAIL full_ready b%0d: got %b exp 1", b, in_ready_o); else pass_cnt++;
      tick();
      check_cnt++;
      if (out_valid_o !== 1'b1 || out_data_o !== d || out_strb_o !== s || out_last_o !== (b == 3))
        $display("FAIL full_beat b%0d: got v=%b s=%h l=%b d=%h exp v=1 s=%h l=%b d=%h",
                 b, out_valid_o, out_strb_o, out_last_o, out_data_o, s, (b == 3), d);
      else pass_cnt++;
    end
    in_valid_i = 1'b0;
    check_cnt++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) $display("FAIL full_drain: got busy=%b done=%b exp 1 0", busy_o, done_o); else pass_cnt++;
    tick();
    check_cnt++;
    if (done_o !== 1'b1 || out_valid_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL full_done: got done=%b v=%b busy=%b exp 1 0 0", done_o, out_valid_o, busy_o);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (done_o !== 1'b0) $display("FAIL full_done_pulse: got %b exp 0", done_o); else pass_cnt++;
  endtask

  task automatic test_mask_tail();
    logic [DW-1:0] exp_d;
    for (int i = 0; i < NB; i++)
      exp_d[8*i +: 8] = (i < 5) ? 8'hAA : ((i % 2 == 0) ? 8'h80 : 8'hFF);
    out_ready_i = 1'b1;
    do_start(32'd3, 5'd5);
    for (int b = 0; b < 3; b++) begin
      in_valid_i = 1'b1; in_data_i = {32{8'hAA}}; in_strb_i = 32'hFFFF_FFFF;
      tick();
      check_cnt++;
      if (b < 2) begin
        if (out_data_o !== {32{8'hAA}} || out_strb_o !== 32'hFFFF_FFFF || out_last_o !== 1'b0)
          $display("FAIL mask_pre b%0d: got s=%h l=%b d=%h exp s=ffffffff l=0", b, out_strb_o, out_last_o, out_data_o);
        else pass_cnt++;
      end else begin
        if (out_data_o !== exp_d || out_strb_o !== 32'h0000_001F || out_last_o !== 1'b1)
          $display("FAIL mask_tail: got s=%h l=%b d=%h exp s=0000001f l=1 d=%h", out_strb_o, out_last_o, out_data_o, exp_d);
        else pass_cnt++;
      end
    end
    drain_idle();
  endtask

  task automatic test_single_beat();
    logic [DW-1:0] exp_d;
    exp_d = {8{32'hDEAD_BEEF}};
    exp_d[255:248] = 8'hFF;
    out_ready_i = 1'b1;
    do_start(32'd1, 5'd31);
    in_valid_i = 1'b1; in_data_i = {8{32'hDEAD_BEEF}}; in_strb_i = 32'hFFFF_FFFF;
    tick();
    in_valid_i = 1'b0;
    check_cnt++;
    if (out_valid_o !== 1'b1 || out_strb_o !== 32'h7FFF_FFFF || out_last_o !== 1'b1 || out_data_o !== exp_d)
      $display("FAIL single_beat: got v=%b s=%h l=%b d=%h exp v=1 s=7fffffff l=1 d=%h",
               out_valid_o, out_strb_o, out_last_o, out_data_o, exp_d);
    else pass_cnt++;
    drain_idle();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] prev_d, exp_d;
    logic [NB-1:0] exp_s;
    bit prev_stall;
    int sent, recv, cyc;
    sent = 0; recv = 0; cyc = 0; prev_stall = 1'b0; prev_d = '0;
    do_start(32'd64, 5'd10);
    while (recv < 64 && cyc < 2000) begin
      if (prev_stall) begin
        check_cnt++;
        if (out_valid_o !== 1'b1 || out_data_o !== prev_d)
          $display("FAIL bp_stable: got v=%b d=%h exp v=1 d=%h", out_valid_o, out_data_o, prev_d);
        else pass_cnt++;
      end
      out_ready_i = (sent < 32) ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid_i  = (sent < 64);
      in_data_i   = {8{32'(sent)}};
      in_strb_i   = 32'hFFFF_FFFF;
      #1;
      if (sent >= 32 && sent < 64) begin
        check_cnt++;
        if (in_ready_o !== 1'b1) $display("FAIL bp_throughput: got ready=%b exp 1 at beat %0d", in_ready_o, sent); else pass_cnt++;
      end
      if (out_valid_o && out_ready_i) begin
        exp_d = {8{32'(recv)}};
        exp_s = 32'hFFFF_FFFF;
        if (recv == 63) begin
          for (int i = 10; i < NB; i++) exp_d[8*i +: 8] = (i % 2 == 0) ? 8'h80 : 8'hFF;
          exp_s = 32'h0000_03FF;
        end
        check_cnt++;
        if (out_data_o !== exp_d || out_strb_o !== exp_s || out_last_o !== (recv == 63))
          $display("FAIL bp_beat %0d: got s=%h l=%b d=%h exp s=%h l=%b d=%h",
                   recv, out_strb_o, out_last_o, out_data_o, exp_s, (recv == 63), exp_d);
        else pass_cnt++;
        recv++;
      end
      prev_stall = out_valid_o & ~out_ready_i;
      prev_d     = out_data_o;
      if (in_valid_i && in_ready_o) sent++;
      tick();
      cyc++;
    end
    in_valid_i = 1'b0;
    check_cnt++;
    if (recv != 64 || sent != 64) $display("FAIL bp_count: got sent=%0d recv=%0d exp 64 64", sent, recv); else pass_cnt++;
    check_cnt++;
    if (done_o !== 1'b1) $display("FAIL bp_done: got %b exp 1", done_o); else pass_cnt++;
    drain_idle();
  endtask

  task automatic test_zero_len();
    out_ready_i = 1'b1;
    in_valid_i = 1'b1; in_data_i = {8{32'h5555_5555}}; in_strb_i = 32'hFFFF_FFFF;
    start_i = 1'b1; tot_len_i = 32'd0; lftovr_i = 5'd0;
    #1;
    check_cnt++;
    if (in_ready_o !== 1'b0) $display("FAIL zero_ready_idle: got %b exp 0", in_ready_o); else pass_cnt++;
    tick();
    start_i = 1'b0;
    check_cnt++;
    if (done_o !== 1'b1 || in_ready_o !== 1'b0 || busy_o !== 1'b0 || out_valid_o !== 1'b0)
      $display("FAIL zero_done: got done=%b rdy=%b busy=%b v=%b exp 1 0 0 0", done_o, in_ready_o, busy_o, out_valid_o);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (done_o !== 1'b0 || in_ready_o !== 1'b0) $display("FAIL zero_after: got done=%b rdy=%b exp 0 0", done_o, in_ready_o); else pass_cnt++;
    in_valid_i = 1'b0;
  endtask

  task automatic test_start_ignored();
    out_ready_i = 1'b1;
    do_start(32'd2, 5'd0);
    in_valid_i = 1'b1; in_data_i = {8{32'h0BAD_F00D}}; in_strb_i = 32'hFFFF_FFFF;
    tick();
    check_cnt++;
    if (out_last_o !== 1'b0) $display("FAIL ign_beat0: got last=%b exp 0", out_last_o); else pass_cnt++;
    start_i = 1'b1; tot_len_i = 32'd5; lftovr_i = 5'd3;
    in_data_i = {8{32'hCAFE_0001}};
    tick();
    start_i = 1'b0; in_valid_i = 1'b0;
    check_cnt++;
    if (out_last_o !== 1'b1 || out_strb_o !== 32'hFFFF_FFFF || out_data_o !== {8{32'hCAFE_0001}})
      $display("FAIL ign_beat1: got l=%b s=%h d=%h exp l=1 s=ffffffff", out_last_o, out_strb_o, out_data_o);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (done_o !== 1'b1) $display("FAIL ign_done: got %b exp 1", done_o); else pass_cnt++;
    drain_idle();
  endtask

  task automatic test_abort(input bit use_rst);
    out_ready_i = 1'b1;
    do_start(32'd8, 5'd0);
    for (int b = 0; b < 2; b++) begin
      in_valid_i = 1'b1; in_data_i = {8{32'h7700_0000 + 32'(b)}}; in_strb_i = 32'hFFFF_FFFF;
      tick();
    end
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    check_cnt++;
    if (out_valid_o !== 1'b1) $display("FAIL abort_pre rst=%0b: got v=%b exp 1", use_rst, out_valid_o); else pass_cnt++;
    if (use_rst) begin
      rst_ni = 1'b0;
      #2;
      rst_ni = 1'b1;
      tick();
    end else begin
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
    end
    check_cnt++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || in_ready_o !== 1'b0 || out_data_o !== '0 || out_strb_o !== '0)
      $display("FAIL abort_state rst=%0b: got v=%b busy=%b rdy=%b d=%h s=%h exp all 0",
               use_rst, out_valid_o, busy_o, in_ready_o, out_data_o, out_strb_o);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      check_cnt++;
      if (done_o !== 1'b0) $display("FAIL abort_no_done rst=%0b cyc%0d: got %b exp 0", use_rst, k, done_o); else pass_cnt++;
      tick();
    end
    out_ready_i = 1'b1;
    do_start(32'd2, 5'd3);
    in_valid_i = 1'b1; in_data_i = {8{32'h1234_5678}}; in_strb_i = 32'hFFFF_FFFF;
    tick();
    check_cnt++;
    if (out_last_o !== 1'b0 || out_strb_o !== 32'hFFFF_FFFF)
      $display("FAIL abort_new0 rst=%0b: got l=%b s=%h exp l=0 s=ffffffff", use_rst, out_last_o, out_strb_o);
    else pass_cnt++;
    tick();
    in_valid_i = 1'b0;
    check_cnt++;
    if (out_last_o !== 1'b1 || out_strb_o !== 32'h0000_0007 || out_data_o[23:0] !== 24'h345678 || out_data_o[31:24] !== 8'hFF)
      $display("FAIL abort_new1 rst=%0b: got l=%b s=%h d=%h exp l=1 s=00000007", use_rst, out_last_o, out_strb_o, out_data_o);
    else pass_cnt++;
    drain_idle();
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_mask_tail();
    test_single_beat();
    test_backpressure();
    test_zero_len();
    test_start_ignored();
    test_abort(1'b0);
    test_abort(1'b1);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
